rd_port_arbiter: RTL

Round-robin arbiter that shares the CGRA's single 512-bit memory read port between `NUM_REQ` requesters: the configuration fetcher (index 0) and the execution unit's data-stream readers (index 1..). It replaces the plain OR of per-unit read requests at the top level. It grants the port to one requester at a time, holds the grant for a bounded burst, and gates `available_read` so that only the granted requester sees valid data.

---
 rtl/rd_port_arbiter.sv | 136 +++++++++++++
 1 files changed

// File: rtl/rd_port_arbiter.sv
// Round-robin arbiter sharing the single wide memory read port between
// the configuration fetcher (index 0) and the data-stream readers (1..).
// A grant is held until the requester lets go or it has taken MAX_BURST
// beats while someone else is waiting.
module rd_port_arbiter #(
  parameter int unsigned NUM_REQ    = 2,
  parameter int unsigned DATA_WIDTH = 512,
  parameter int unsigned MAX_BURST  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_REQ-1:0]    req,
  input  logic                  available_read,
  input  logic [DATA_WIDTH-1:0] rd_data,
  output logic                  req_rd_data,
  output logic [NUM_REQ-1:0]    avail_out,
  output logic [DATA_WIDTH-1:0] rd_data_out,
  output logic [NUM_REQ-1:0]    grant,
  output logic                  busy
);

  localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned CNT_W = $clog2(MAX_BURST) + 1;

  localparam logic [CNT_W-1:0] MAX_C    = CNT_W'(MAX_BURST);
  localparam logic [CNT_W-1:0] LAST_C   = CNT_W'(MAX_BURST - 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REQ - 1);

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_GRANT = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   gnt_idx_q, gnt_idx_d;
  logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0]   beat_cnt_q, beat_cnt_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;

  logic               pick_found;
  logic [IDX_W-1:0]   pick_idx;
  logic               cur_req;
  logic               beat;
  logic               others_wait;
  logic               release_c;

  // State register with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      gnt_idx_q  <= '0;
      rr_ptr_q   <= '0;
      beat_cnt_q <= '0;
      grant_q    <= '0;
    end else begin
      state_q    <= state_d;
      gnt_idx_q  <= gnt_idx_d;
      rr_ptr_q   <= rr_ptr_d;
      beat_cnt_q <= beat_cnt_d;
      grant_q    <= grant_d;
    end
  end

  // First pending request at or above rr_ptr, wrapping around
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      int unsigned pos;
      pos = 32'(rr_ptr_q) + i;
      if (pos >= NUM_REQ) pos = pos - NUM_REQ;
      if (!pick_found && req[IDX_W'(pos)]) begin
        pick_found = 1'b1;
        pick_idx   = IDX_W'(pos);
      end
    end
  end

  // Live view of the granted requester and the beat it may take this cycle
  always_comb begin
    cur_req     = req[gnt_idx_q];
    beat        = (state_q == S_GRANT) && cur_req && available_read;
    others_wait = |(req & ~grant_q);
  end

  // Next-state logic: grant, burst counting, release and pointer advance
  always_comb begin
    state_d    = state_q;
    gnt_idx_d  = gnt_idx_q;
    rr_ptr_d   = rr_ptr_q;
    beat_cnt_d = beat_cnt_q;
    grant_d    = grant_q;
    release_c  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (pick_found) begin
          state_d    = S_GRANT;
          gnt_idx_d  = pick_idx;
          grant_d    = NUM_REQ'(1) << pick_idx;
          beat_cnt_d = '0;
        end
      end
      S_GRANT: begin
        if (!cur_req) begin
          release_c = 1'b1;
        end else if (beat) begin
          // Counter saturates at MAX_BURST; preempt only when someone waits
          if ((beat_cnt_q >= LAST_C) && others_wait) begin
            release_c = 1'b1;
          end else if (beat_cnt_q < MAX_C) begin
            beat_cnt_d = beat_cnt_q + CNT_W'(1);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (release_c) begin
      state_d    = S_IDLE;
      grant_d    = '0;
      beat_cnt_d = '0;
      rr_ptr_d   = (gnt_idx_q == LAST_IDX) ? '0 : gnt_idx_q + IDX_W'(1);
    end
  end

  // Upstream request and per-requester valid follow the registered grant
  always_comb begin
    req_rd_data = (state_q == S_GRANT) && cur_req;
    avail_out   = grant_q & req & {NUM_REQ{available_read}};
    rd_data_out = rd_data;
    grant       = grant_q;
    busy        = (state_q == S_GRANT);
  end

endmodule
